hyper_eot_classifier: RTL

Per-channel end-of-transfer classifier for the multi-channel HyperBus uDMA macro. It records the direction (read or write) of each issued HyperBus transaction in a small per-channel FIFO. When the controller signals end-of-transfer, it pops that FIFO and raises a registered read-done or write-done event toward the uDMA event bus. It supersedes the single-flag direction tracker. It supports NB_CH channels, several outstanding transactions per channel, and error reporting for overflow and orphan EOTs.

---
 rtl/hyper_eot_classifier_if.sv | 28 ++
 rtl/hyper_eot_classifier.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hyper_eot_classifier_if.sv
// Transaction-strobe and end-of-transfer event bundle for hyper_eot_classifier.
// master drives the per-channel strobes; slave returns events, levels and sticky flags.
interface hyper_eot_classifier_if #(
  parameter int NB_CH = 2,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
);
  logic [NB_CH-1:0]       txn_rd_i;
  logic [NB_CH-1:0]       txn_wr_i;
  logic [NB_CH-1:0]       eot_i;
  logic [NB_CH-1:0]       clr_i;
  logic [NB_CH-1:0]       eot_rd_o;
  logic [NB_CH-1:0]       eot_wr_o;
  logic [NB_CH*LVL_W-1:0] level_o;
  logic [NB_CH-1:0]       ovf_o;
  logic [NB_CH-1:0]       orphan_o;
  logic [NB_CH-1:0]       proto_err_o;

  modport master (
    output txn_rd_i, txn_wr_i, eot_i, clr_i,
    input  eot_rd_o, eot_wr_o, level_o, ovf_o, orphan_o, proto_err_o
  );

  modport slave (
    input  txn_rd_i, txn_wr_i, eot_i, clr_i,
    output eot_rd_o, eot_wr_o, level_o, ovf_o, orphan_o, proto_err_o
  );
endinterface

// File: rtl/hyper_eot_classifier.sv
// Per-channel direction FIFO that classifies HyperBus EOTs as read/write-done events, 1-cycle latency.
// No backpressure: full-FIFO pushes are dropped and flagged, empty-FIFO EOTs fall back to the last direction.
module hyper_eot_classifier #(
  parameter int NB_CH = 2,
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  hyper_eot_classifier_if.slave bus
);

  logic [DEPTH-1:0] fifo_q [NB_CH];
  logic [DEPTH-1:0] fifo_d [NB_CH];
  logic [PTR_W-1:0] wptr_q [NB_CH];
  logic [PTR_W-1:0] wptr_d [NB_CH];
  logic [PTR_W-1:0] rptr_q [NB_CH];
  logic [PTR_W-1:0] rptr_d [NB_CH];
  logic [LVL_W-1:0] lvl_q  [NB_CH];
  logic [LVL_W-1:0] lvl_d  [NB_CH];

  logic [NB_CH-1:0] last_dir_q, last_dir_d;
  logic [NB_CH-1:0] eot_rd_q, eot_rd_d;
  logic [NB_CH-1:0] eot_wr_q, eot_wr_d;
  logic [NB_CH-1:0] ovf_q, ovf_d;
  logic [NB_CH-1:0] orphan_q, orphan_d;
  logic [NB_CH-1:0] perr_q, perr_d;

  logic [NB_CH-1:0] empty, full, head, pop, push_req, push;
  logic [NB_CH*LVL_W-1:0] level_flat;

  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    lvl_d      = lvl_q;
    last_dir_d = last_dir_q;
    ovf_d      = ovf_q;
    orphan_d   = orphan_q;
    perr_d     = perr_q;
    eot_rd_d   = '0;
    eot_wr_d   = '0;
    empty      = '0;
    full       = '0;
    head       = '0;
    pop        = '0;
    push_req   = '0;
    push       = '0;
    for (int c = 0; c < NB_CH; c++) begin
      empty[c]    = (lvl_q[c] == '0);
      full[c]     = (lvl_q[c] == LVL_W'(DEPTH));
      head[c]     = fifo_q[c][rptr_q[c]];
      pop[c]      = bus.eot_i[c] & ~empty[c];
      push_req[c] = bus.txn_rd_i[c] ^ bus.txn_wr_i[c];
      // A pop in the same cycle frees the slot the full-FIFO push lands in.
      push[c]     = push_req[c] & (~full[c] | pop[c]);
      if (bus.clr_i[c]) begin
        wptr_d[c]     = '0;
        rptr_d[c]     = '0;
        lvl_d[c]      = '0;
        last_dir_d[c] = 1'b0;
        ovf_d[c]      = 1'b0;
        orphan_d[c]   = 1'b0;
        perr_d[c]     = 1'b0;
      end else begin
        if (push[c]) begin
          fifo_d[c][wptr_q[c]] = bus.txn_rd_i[c];
          wptr_d[c]            = wptr_q[c] + PTR_W'(1);
        end
        if (pop[c]) begin
          rptr_d[c]     = rptr_q[c] + PTR_W'(1);
          last_dir_d[c] = head[c];
        end
        lvl_d[c] = lvl_q[c] + LVL_W'(push[c]) - LVL_W'(pop[c]);
        // Orphan EOTs reuse the last popped direction, like the old single-flag tracker.
        eot_rd_d[c] = bus.eot_i[c] &  (empty[c] ? last_dir_q[c] : head[c]);
        eot_wr_d[c] = bus.eot_i[c] & ~(empty[c] ? last_dir_q[c] : head[c]);
        ovf_d[c]    = ovf_q[c]    | (push_req[c] & full[c] & ~pop[c]);
        orphan_d[c] = orphan_q[c] | (bus.eot_i[c] & empty[c]);
        perr_d[c]   = perr_q[c]   | (bus.txn_rd_i[c] & bus.txn_wr_i[c]);
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NB_CH; c++) begin
        fifo_q[c] <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        lvl_q[c]  <= '0;
      end
      last_dir_q <= '0;
      eot_rd_q   <= '0;
      eot_wr_q   <= '0;
      ovf_q      <= '0;
      orphan_q   <= '0;
      perr_q     <= '0;
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        fifo_q[c] <= fifo_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        lvl_q[c]  <= lvl_d[c];
      end
      last_dir_q <= last_dir_d;
      eot_rd_q   <= eot_rd_d;
      eot_wr_q   <= eot_wr_d;
      ovf_q      <= ovf_d;
      orphan_q   <= orphan_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    level_flat = '0;
    for (int c = 0; c < NB_CH; c++) begin
      level_flat[c*LVL_W +: LVL_W] = lvl_q[c];
    end
  end

  assign bus.eot_rd_o    = eot_rd_q;
  assign bus.eot_wr_o    = eot_wr_q;
  assign bus.level_o     = level_flat;
  assign bus.ovf_o       = ovf_q;
  assign bus.orphan_o    = orphan_q;
  assign bus.proto_err_o = perr_q;

endmodule
